// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter width and sync-window helper.
package vga_timing_pkg;

    // Default 640x480@60 timing (pixels / lines)
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_H_MAX     = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_V_MAX     = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Raster counters are this wide; totals must not exceed CNT_LIMIT
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned CNT_LIMIT = 1 << CNT_W;

    // Inclusive first/last counter value of a sync pulse
    typedef struct packed {
        logic [31:0] first;
        logic [31:0] last;
    } sync_win_t;

    // Sync pulse starts after the visible area and front porch
    function automatic sync_win_t sync_window(input int unsigned display,
                                              input int unsigned front,
                                              input int unsigned width);
        sync_win_t w;
        w.first = display + front;
        w.last  = display + front + width - 1;
        return w;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// hpos/vpos wrap counter pair: hpos carries into vpos; both advance on en_i.
// Also exposes the next-state values so sync can be decoded with zero lag.
module raster_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_MAX = DEF_H_MAX,
    parameter int unsigned V_MAX = DEF_V_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] hpos_o,
    output logic [CNT_W-1:0] vpos_o,
    output logic [CNT_W-1:0] hpos_nxt_c,
    output logic [CNT_W-1:0] vpos_nxt_c
);

    logic [CNT_W-1:0] hpos_q, hpos_d;
    logic [CNT_W-1:0] vpos_q, vpos_d;
    logic             h_wrap;

    // Next-state: hpos wraps at H_MAX-1, vpos steps (and wraps) on hpos wrap
    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        h_wrap = (hpos_q == CNT_W'(H_MAX - 1));
        if (en_i) begin
            if (h_wrap) begin
                hpos_d = '0;
                if (vpos_q == CNT_W'(V_MAX - 1)) begin
                    vpos_d = '0;
                end else begin
                    vpos_d = vpos_q + CNT_W'(1);
                end
            end else begin
                hpos_d = hpos_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign hpos_o     = hpos_q;
    assign vpos_o     = vpos_q;
    assign hpos_nxt_c = hpos_d;
    assign vpos_nxt_c = vpos_d;

endmodule

// File: rtl/vga_sync_timing.sv
// Free-running VGA raster timing generator (default 640x480@60, 800x525 total).
// Optional HVSYNC_PIX_CE_EN adds pix_ce: raster advances only when pix_ce=1.
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned SYNC_NEG  = 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef HVSYNC_PIX_CE_EN
    input  logic             pix_ce,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos
);

    localparam int unsigned H_MAX     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_MAX     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam sync_win_t   H_WIN     = sync_window(H_DISPLAY, H_FRONT, H_SYNC);
    localparam sync_win_t   V_WIN     = sync_window(V_DISPLAY, V_FRONT, V_SYNC);
    localparam logic        SYNC_IDLE = (SYNC_NEG != 0);

    // Totals must fit the counter width
    if (H_MAX > CNT_LIMIT) begin : g_hmax_chk
        $error("vga_sync_timing: H_MAX exceeds counter range");
    end
    if (V_MAX > CNT_LIMIT) begin : g_vmax_chk
        $error("vga_sync_timing: V_MAX exceeds counter range");
    end

    logic             ce;
    logic [CNT_W-1:0] hpos_nxt, vpos_nxt;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

`ifdef HVSYNC_PIX_CE_EN
    assign ce = pix_ce;
`else
    assign ce = 1'b1;
`endif

    raster_counter #(
        .H_MAX (H_MAX),
        .V_MAX (V_MAX)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .en_i       (ce),
        .hpos_o     (hpos),
        .vpos_o     (vpos),
        .hpos_nxt_c (hpos_nxt),
        .vpos_nxt_c (vpos_nxt)
    );

    // Sync decode from next-state counters so registered sync aligns with hpos/vpos
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (ce) begin
            hsync_d = ((32'(hpos_nxt) >= H_WIN.first) && (32'(hpos_nxt) <= H_WIN.last))
                      ? ~SYNC_IDLE : SYNC_IDLE;
            vsync_d = ((32'(vpos_nxt) >= V_WIN.first) && (32'(vpos_nxt) <= V_WIN.last))
                      ? ~SYNC_IDLE : SYNC_IDLE;
        end
    end

    // Sync registers, inactive level in reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (32'(hpos) < H_DISPLAY) && (32'(vpos) < V_DISPLAY);

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: a default-timing instance and a small-timing,
// active-high-sync instance, both compared every clock against a raster
// position derived from the number of enabled clock edges since reset.
module tb_vga_sync_timing;

    localparam int unsigned A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int unsigned A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int unsigned B_HD = 20,  B_HF = 4,  B_HS = 6,  B_HB = 3;
    localparam int unsigned B_VD = 12,  B_VF = 2,  B_VS = 2,  B_VB = 3;
`ifdef HVSYNC_PIX_CE_EN
    localparam int CE_DIV = 3;
`else
    localparam int CE_DIV = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       ce_a = 1'b1, ce_b = 1'b1;
    logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;
    logic [9:0] hp_a, vp_a, hp_b, vp_b;

    int checks = 0;
    int errors = 0;
    int na = 0, nb = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int l5_clks = 0, l5_hslow = 0;
    bit l5_done = 1'b0;

    always #5 clk = ~clk;

    vga_sync_timing u_dut_a (
        .clk        (clk),
        .reset      (rst_a),
`ifdef HVSYNC_PIX_CE_EN
        .pix_ce     (ce_a),
`endif
        .hsync      (hs_a),
        .vsync      (vs_a),
        .display_on (de_a),
        .hpos       (hp_a),
        .vpos       (vp_a)
    );

    vga_sync_timing #(
        .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .SYNC_NEG  (0)
    ) u_dut_b (
        .clk        (clk),
        .reset      (rst_b),
`ifdef HVSYNC_PIX_CE_EN
        .pix_ce     (ce_b),
`endif
        .hsync      (hs_b),
        .vsync      (vs_b),
        .display_on (de_b),
        .hpos       (hp_b),
        .vpos       (vp_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: position is (edges mod H_MAX, (edges div H_MAX) mod V_MAX)
    task automatic check_point(input string who, input int n,
                               input logic [9:0] hp, input logic [9:0] vp,
                               input logic hs, input logic vs, input logic de,
                               input int unsigned hd, input int unsigned hf,
                               input int unsigned hw, input int unsigned hb,
                               input int unsigned vd, input int unsigned vf,
                               input int unsigned vw, input int unsigned vb,
                               input bit neg);
        int unsigned hm, vm, h, v;
        logic act, eh, ev, ed;
        hm  = hd + hf + hw + hb;
        vm  = vd + vf + vw + vb;
        h   = int'(n) % hm;
        v   = (int'(n) / hm) % vm;
        act = !neg;
        eh  = (h >= hd + hf && h < hd + hf + hw) ? act : !act;
        ev  = (v >= vd + vf && v < vd + vf + vw) ? act : !act;
        ed  = (h < hd) && (v < vd);
        check($sformatf("%s_hpos", who), 32'(hp), h);
        check($sformatf("%s_vpos", who), 32'(vp), v);
        check($sformatf("%s_hsync@%0d,%0d", who, h, v), 32'(hs), 32'(eh));
        check($sformatf("%s_vsync@%0d,%0d", who, h, v), 32'(vs), 32'(ev));
        check($sformatf("%s_display_on@%0d,%0d", who, h, v), 32'(de), 32'(ed));
    endtask

    // Enabled-edge counts since reset
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) na <= 0;
        else if (ce_a) na <= na + 1;
    end
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) nb <= 0;
        else if (ce_b) nb <= nb + 1;
    end

    // Pixel strobes: A pulsed 1-in-CE_DIV, B random when the strobe exists
    always @(negedge clk) begin
        cyc++;
        #2;
        ce_a = (CE_DIV == 1) || (cyc % CE_DIV == 0);
`ifdef HVSYNC_PIX_CE_EN
        ce_b = 1'($urandom_range(0, 1));
`endif
    end

    // Per-clock comparison plus line-5 window measurement on A
    always @(negedge clk) begin
        if (chk_en) begin
            check_point("a", na, hp_a, vp_a, hs_a, vs_a, de_a,
                        A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, 1'b1);
            check_point("b", nb, hp_b, vp_b, hs_b, vs_b, de_b,
                        B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, 1'b0);
            if (!rst_a && !l5_done) begin
                if (vp_a == 10'd5) begin
                    l5_clks++;
                    if (hs_a == 1'b0) l5_hslow++;
                end else if (l5_clks != 0) begin
                    check("a_line5_clocks", l5_clks, 800 * CE_DIV);
                    check("a_line5_hsync_low_clocks", l5_hslow, 96 * CE_DIV);
                    l5_done = 1'b1;
                end
            end
        end
    end

    initial begin
        int target;
        int i;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // First enabled edge after release moves hpos to 1
        for (i = 0; i < 20 && na != 1; i++) @(negedge clk);
        check("a_first_step_reached", 32'(na == 1), 32'd1);
        check("a_first_step_hpos", 32'(hp_a), 32'd1);

        // Run A into line 6, then reset it mid-line
        target = 6 * 800 + 300;
        for (i = 0; i < 30000 && na != target; i++) @(negedge clk);
        check("a_midframe_reached", 32'(na == target), 32'd1);
        check("a_line5_measured", 32'(l5_done), 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        check("a_async_hpos", 32'(hp_a), 32'd0);
        check("a_async_vpos", 32'(vp_a), 32'd0);
        check("a_async_hsync", 32'(hs_a), 32'd1);
        check("a_async_vsync", 32'(vs_a), 32'd1);
        check("a_async_display_on", 32'(de_a), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_a = 1'b0;

        // Random mid-frame resets on B
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(150, 900)) @(negedge clk);
            #2;
            rst_b = 1'b1;
            #1;
            check("b_async_hpos", 32'(hp_b), 32'd0);
            check("b_async_vpos", 32'(vp_b), 32'd0);
            check("b_async_hsync", 32'(hs_b), 32'd0);
            check("b_async_vsync", 32'(vs_b), 32'd0);
            check("b_async_display_on", 32'(de_b), 32'd1);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #2;
            rst_b = 1'b0;
        end

        // Let B run past at least one full frame after the last reset
        repeat (1500 * CE_DIV) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
